// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: request size codes,
// FSM state encoding and the fixed data width.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = DATA_W / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WRITE  = 3'd2,
    ST_ERR    = 3'd3,
    ST_RESP   = 3'd4
  } mem_state_e;

endpackage

// File: rtl/mem_lane_logic.sv
// Byte-lane datapath: extracts and sign/zero-extends sub-word loads, and
// merges sub-word store data into the old RAM word. Purely combinational.
module mem_lane_logic
  import mem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [15:0]       wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane(s), extend for loads, replace for stores.
  always_comb begin
    byte_sel = rdata_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o   = rdata_i;
    merge_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        case (lane_i)
          2'd1:    merge_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_o[23:16] = wdata_i[7:0];
          2'd3:    merge_o[31:24] = wdata_i[7:0];
          default: merge_o[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & half_sel[15]}}, half_sel};
        if (lane_i[1]) merge_o[31:16] = wdata_i;
        else           merge_o[15:0]  = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the single-port data RAM. Accepts one byte-addressed
// load/store at a time, does read-modify-write for sub-word stores and
// returns a response with an error flag for malformed requests.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready
// are both 1. ReqReady is 1 only in IDLE. RspValid is 1 only in RESP, and
// RspData/RspErr are register outputs that hold until RspReady is seen.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 32
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic         ReqWrite,
  input  logic [31:0]  ReqAddr,
  input  logic [1:0]   ReqSize,
  input  logic         ReqSigned,
  input  logic [M-1:0] ReqWData,
  output logic         RspValid,
  input  logic         RspReady,
  output logic [M-1:0] RspData,
  output logic         RspErr,
  output logic [N-1:0] MemAddr,
  output logic [M-1:0] MemDataIn,
  output logic         MemWR,
  input  logic [M-1:0] MemDataOut,
  output mem_state_e   DbgState
);

  mem_state_e   state_q, state_d;
  logic [N+1:0] addr_q, addr_d;
  logic [1:0]   size_q, size_d;
  logic         write_q, write_d;
  logic         signed_q, signed_d;
  logic [M-1:0] wdata_q, wdata_d;
  logic [M-1:0] old_q, old_d;
  logic [M-1:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  logic         req_ok;
  logic [M-1:0] lane_rdata;
  logic [M-1:0] load_data;
  logic [M-1:0] merge_data;

  // Request legality: size code, natural alignment, and address inside RAM.
  assign req_ok = (ReqSize != SZ_ILL)
               && !(ReqSize == SZ_HALF && ReqAddr[0])
               && !(ReqSize == SZ_WORD && ReqAddr[1:0] != 2'b00)
               && ((ReqAddr >> (N + 2)) == 32'd0);

  // Loads extract from live RAM data; the merge step works on the saved word.
  assign lane_rdata = (state_q == ST_WRITE) ? old_q : MemDataOut;

  mem_lane_logic u_lane (
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .signed_i (signed_q),
    .rdata_i  (lane_rdata),
    .wdata_i  (wdata_q[15:0]),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  assign MemAddr  = addr_q[N+1:2];
  assign RspData  = rsp_data_q;
  assign RspErr   = rsp_err_q;
  assign DbgState = state_q;

  // State and request registers; reset aborts any operation in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      old_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      signed_q   <= signed_d;
      wdata_q    <= wdata_d;
      old_q      <= old_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and output decode; RAM strobes depend on registered state only.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    signed_d   = signed_q;
    wdata_d    = wdata_q;
    old_d      = old_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ReqReady   = 1'b0;
    RspValid   = 1'b0;
    MemWR      = 1'b0;
    MemDataIn  = '0;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          addr_d   = ReqAddr[N+1:0];
          size_d   = ReqSize;
          write_d  = ReqWrite;
          signed_d = ReqSigned;
          wdata_d  = ReqWData;
          state_d  = req_ok ? ST_ACCESS : ST_ERR;
        end
      end
      ST_ACCESS: begin
        rsp_err_d = 1'b0;
        if (!write_q) begin
          rsp_data_d = load_data;
          state_d    = ST_RESP;
        end else if (size_q == SZ_WORD) begin
          MemWR      = 1'b1;
          MemDataIn  = wdata_q;
          rsp_data_d = '0;
          state_d    = ST_RESP;
        end else begin
          old_d   = MemDataOut;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        MemWR      = 1'b1;
        MemDataIn  = merge_data;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = ST_RESP;
      end
      ST_ERR: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        RspValid = 1'b1;
        if (RspReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
